// File: rtl/ddr3_pixel_reader_supersimple.sv
// Avalon-MM burst reader that replays a stored pixel frame from DDR3 and unpacks 256-bit words
// into a valid/ready pixel stream. Optional DDR3_READER_UNDERRUN_CNT_EN adds an underrun counter.
module ddr3_pixel_reader_supersimple #(
  parameter int          OUT_WIDTH     = 16,
  parameter int          BURST_LEN     = 8,
  parameter int          NUM_PIXELS    = 2764800,
  parameter logic [31:0] START_ADDRESS = 32'h3600_0000,
  parameter int          FIFO_DEPTH    = 64
) (
  input  logic                 ddr3_clk,
  input  logic                 ddr3_clk_reset_n,
  input  logic                 enable,
  output logic [26:0]          ddr3_read_address,
  output logic                 ddr3_read,
  output logic [7:0]           ddr3_burstcount,
  input  logic                 ddr3_waitrequest,
  input  logic [255:0]         ddr3_readdata,
  input  logic                 ddr3_readdatavalid,
  output logic [OUT_WIDTH-1:0] pixel,
  output logic                 pixel_valid,
  input  logic                 pixel_ready,
  output logic                 pixel_eof,
  output logic [7:0]           fifo_level
`ifdef DDR3_READER_UNDERRUN_CNT_EN
  ,
  output logic [15:0]          underrun_count
`endif
);

  localparam int PPW       = 256 / OUT_WIDTH;
  localparam int NUM_READS = NUM_PIXELS / PPW / BURST_LEN;
  localparam int RC_W      = (NUM_READS > 1) ? $clog2(NUM_READS) : 1;
  localparam int PC_W      = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
  localparam int IX_W      = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int AW        = $clog2(FIFO_DEPTH);
  localparam int CW        = $clog2(FIFO_DEPTH + 1);
  localparam int SW        = CW + 2;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_SPACE = 2'd1,
    ST_READ       = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [26:0]     addr_q, addr_d;
  logic [RC_W-1:0] rc_q, rc_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   level_q, level_d;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [255:0]    mem_q [FIFO_DEPTH];
  logic [255:0]    word_q, word_d;
  logic            word_valid_q, word_valid_d;
  logic [IX_W-1:0] idx_q, idx_d;
  logic [PC_W-1:0] pc_q, pc_d;

  logic            accept_s;
  logic            space_ok_s;
  logic [SW-1:0]   need_s;
  logic            fifo_empty_s;
  logic            accept_pix_s;
  logic            last_pix_s;
  logic            load_s;

  // Credit check: a burst may only be issued when its whole return fits in the FIFO.
  assign need_s       = {2'b00, level_q} + {2'b00, inflight_q} + SW'(BURST_LEN);
  assign space_ok_s   = (need_s <= SW'(FIFO_DEPTH));
  assign fifo_empty_s = (level_q == {CW{1'b0}});
  assign accept_pix_s = word_valid_q && pixel_ready;
  assign last_pix_s   = (idx_q == IX_W'(PPW - 1));
  assign load_s       = !fifo_empty_s && (!word_valid_q || (accept_pix_s && last_pix_s));

  assign ddr3_read_address = addr_q;
  assign ddr3_read         = (state_q == ST_READ);
  assign ddr3_burstcount   = 8'(BURST_LEN);
  assign fifo_level        = 8'(level_q);
  assign pixel             = word_q[32'(idx_q) * OUT_WIDTH +: OUT_WIDTH];
  assign pixel_valid       = word_valid_q;
  assign pixel_eof         = word_valid_q && (pc_q == PC_W'(NUM_PIXELS - 1));

  // Issue FSM state, address and burst counter registers.
  always_ff @(posedge ddr3_clk or negedge ddr3_clk_reset_n) begin
    if (!ddr3_clk_reset_n) begin
      state_q <= ST_IDLE;
      addr_q  <= 27'd0;
      rc_q    <= {RC_W{1'b0}};
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rc_q    <= rc_d;
    end
  end

  // Issue FSM next state; the request and address hold while waitrequest stalls it.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rc_d     = rc_q;
    accept_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        addr_d  = START_ADDRESS[31:5];
        rc_d    = {RC_W{1'b0}};
        state_d = ST_WAIT_SPACE;
      end
      ST_WAIT_SPACE: begin
        if (enable && space_ok_s) begin
          state_d = ST_READ;
        end else begin
          state_d = ST_WAIT_SPACE;
        end
      end
      ST_READ: begin
        if (!ddr3_waitrequest) begin
          accept_s = 1'b1;
          rc_d     = rc_q + RC_W'(1);
          if (rc_q == RC_W'(NUM_READS - 1)) begin
            state_d = ST_IDLE;
          end else begin
            addr_d  = addr_q + 27'(BURST_LEN);
            state_d = ST_WAIT_SPACE;
          end
        end else begin
          state_d = ST_READ;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outstanding-beat and FIFO occupancy bookkeeping.
  always_comb begin
    inflight_d = inflight_q;
    level_d    = level_q;
    case ({accept_s, ddr3_readdatavalid})
      2'b10:   inflight_d = inflight_q + CW'(BURST_LEN);
      2'b01:   inflight_d = inflight_q - CW'(1);
      2'b11:   inflight_d = inflight_q + CW'(BURST_LEN - 1);
      default: inflight_d = inflight_q;
    endcase
    case ({ddr3_readdatavalid, load_s})
      2'b10:   level_d = level_q + CW'(1);
      2'b01:   level_d = level_q - CW'(1);
      default: level_d = level_q;
    endcase
  end

  // FIFO storage; every returned beat lands here, the credit check prevents overflow.
  always_ff @(posedge ddr3_clk) begin
    if (ddr3_readdatavalid) begin
      mem_q[wr_ptr_q] <= ddr3_readdata;
    end
  end

  // Counters and FIFO pointers.
  always_ff @(posedge ddr3_clk or negedge ddr3_clk_reset_n) begin
    if (!ddr3_clk_reset_n) begin
      inflight_q <= {CW{1'b0}};
      level_q    <= {CW{1'b0}};
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
    end else begin
      inflight_q <= inflight_d;
      level_q    <= level_d;
      if (ddr3_readdatavalid) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (load_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

  // Unpacker next state: LSB pixel first, next word loads in the same cycle as the last pixel.
  always_comb begin
    word_d       = word_q;
    word_valid_d = word_valid_q;
    idx_d        = idx_q;
    pc_d         = pc_q;
    if (load_s) begin
      word_d       = mem_q[rd_ptr_q];
      word_valid_d = 1'b1;
      idx_d        = {IX_W{1'b0}};
    end else if (accept_pix_s && last_pix_s) begin
      word_valid_d = 1'b0;
      idx_d        = {IX_W{1'b0}};
    end else if (accept_pix_s) begin
      idx_d = idx_q + IX_W'(1);
    end else begin
      idx_d = idx_q;
    end
    if (accept_pix_s) begin
      if (pc_q == PC_W'(NUM_PIXELS - 1)) begin
        pc_d = {PC_W{1'b0}};
      end else begin
        pc_d = pc_q + PC_W'(1);
      end
    end else begin
      pc_d = pc_q;
    end
  end

  // Unpacker and frame pixel counter registers.
  always_ff @(posedge ddr3_clk or negedge ddr3_clk_reset_n) begin
    if (!ddr3_clk_reset_n) begin
      word_q       <= 256'd0;
      word_valid_q <= 1'b0;
      idx_q        <= {IX_W{1'b0}};
      pc_q         <= {PC_W{1'b0}};
    end else begin
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      idx_q        <= idx_d;
      pc_q         <= pc_d;
    end
  end

`ifdef DDR3_READER_UNDERRUN_CNT_EN
  logic        started_q;
  logic [15:0] underrun_q;

  // Saturating count of starved cycles once the first pixel has gone out.
  always_ff @(posedge ddr3_clk or negedge ddr3_clk_reset_n) begin
    if (!ddr3_clk_reset_n) begin
      started_q  <= 1'b0;
      underrun_q <= 16'd0;
    end else begin
      if (accept_pix_s) begin
        started_q <= 1'b1;
      end
      if (started_q && pixel_ready && !word_valid_q && (underrun_q != 16'hFFFF)) begin
        underrun_q <= underrun_q + 16'd1;
      end
    end
  end

  assign underrun_count = underrun_q;
`endif

endmodule

// File: tb/tb_ddr3_pixel_reader_supersimple.sv
// Directed bench for ddr3_pixel_reader_supersimple with a zero-wait Avalon memory model and a
// stream monitor; frame of 256 16-bit pixels at base 0x100 (word address 0x8).
module tb_ddr3_pixel_reader_supersimple;

  localparam int          OW = 16;
  localparam int          BL = 2;
  localparam int          NP = 256;
  localparam logic [31:0] SA = 32'h0000_0100;
  localparam int          FD = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           enable;
  logic [26:0]    ddr3_read_address;
  logic           ddr3_read;
  logic [7:0]     ddr3_burstcount;
  logic           ddr3_waitrequest;
  logic [255:0]   ddr3_readdata;
  logic           ddr3_readdatavalid;
  logic [OW-1:0]  pixel;
  logic           pixel_valid;
  logic           pixel_ready;
  logic           pixel_eof;
  logic [7:0]     fifo_level;
`ifdef DDR3_READER_UNDERRUN_CNT_EN
  logic [15:0]    underrun_count;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  ddr3_pixel_reader_supersimple #(
    .OUT_WIDTH(OW), .BURST_LEN(BL), .NUM_PIXELS(NP), .START_ADDRESS(SA), .FIFO_DEPTH(FD)
  ) dut (
    .ddr3_clk(clk),
    .ddr3_clk_reset_n(rst_n),
    .enable(enable),
    .ddr3_read_address(ddr3_read_address),
    .ddr3_read(ddr3_read),
    .ddr3_burstcount(ddr3_burstcount),
    .ddr3_waitrequest(ddr3_waitrequest),
    .ddr3_readdata(ddr3_readdata),
    .ddr3_readdatavalid(ddr3_readdatavalid),
    .pixel(pixel),
    .pixel_valid(pixel_valid),
    .pixel_ready(pixel_ready),
    .pixel_eof(pixel_eof),
    .fifo_level(fifo_level)
`ifdef DDR3_READER_UNDERRUN_CNT_EN
    ,
    .underrun_count(underrun_count)
`endif
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [26:0] nxt(input logic [26:0] a);
    return (a == 27'h16) ? 27'h8 : a + 27'd2;
  endfunction

  // Stored frame: word at address a holds pixels (a-8)*16 .. (a-8)*16+15, LSB first.
  function automatic logic [255:0] word_of(input logic [26:0] a);
    logic [255:0] w;
    int p0;
    p0 = (int'(a) - 8) * 16;
    for (int j = 0; j < 16; j++) w[j*16 +: 16] = 16'(p0 + j);
    return w;
  endfunction

  // Memory model state
  logic [26:0] rq[$];
  logic [26:0] acc_log[$];
  int acc_cnt = 0, coincide = 0, first_beat_cyc = -1, max_occ = 0, max_level = 0;

  initial begin
    logic [26:0] a;
    ddr3_readdatavalid = 1'b0;
    ddr3_readdata      = 256'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rq.delete();
        ddr3_readdatavalid = 1'b0;
        first_beat_cyc = -1;
      end else begin
        if (int'(fifo_level) + rq.size() > max_occ) max_occ = int'(fifo_level) + rq.size();
        if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
        if (rq.size() > 0) begin
          a = rq.pop_front();
          ddr3_readdata      = word_of(a);
          ddr3_readdatavalid = 1'b1;
          if (first_beat_cyc < 0) first_beat_cyc = cyc;
        end else begin
          ddr3_readdatavalid = 1'b0;
        end
        if (ddr3_read && !ddr3_waitrequest) begin
          acc_cnt++;
          acc_log.push_back(ddr3_read_address);
          for (int b = 0; b < BL; b++) rq.push_back(ddr3_read_address + 27'(b));
          if (ddr3_readdatavalid) coincide++;
        end
      end
    end
  end

  // Stream monitor state
  int exp_pix = 0, pix_total = 0, eof_cnt = 0, first_pv_cyc = -1, bubbles = 0, exp_underrun = 0;
  bit bubble_win = 1'b0, started = 1'b0, prev_hold = 1'b0, prev_eof = 1'b0;
  logic [OW-1:0] prev_pix;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_pix = 0; first_pv_cyc = -1; prev_hold = 1'b0; started = 1'b0; exp_underrun = 0;
      end else begin
        if (prev_hold) begin
          chk("stall_valid", pixel_valid, 1'b1);
          chk("stall_pixel", pixel, prev_pix);
          chk("stall_eof", pixel_eof, prev_eof);
        end
        if (pixel_valid && first_pv_cyc < 0) first_pv_cyc = cyc;
        if (pixel_valid) chk("pix_eof", pixel_eof, (exp_pix == 255));
        else chk("eof_idle", pixel_eof, 1'b0);
        if (started && pixel_ready && !pixel_valid && exp_underrun < 65535) exp_underrun++;
        if (bubble_win && pixel_ready && !pixel_valid) bubbles++;
        if (pixel_valid && pixel_ready) begin
          chk("pix_data", pixel, 16'(exp_pix));
          if (pixel_eof) eof_cnt++;
          exp_pix = (exp_pix + 1) % 256;
          pix_total++;
          started = 1'b1;
        end
        prev_hold = pixel_valid && !pixel_ready;
        prev_pix  = pixel;
        prev_eof  = pixel_eof;
      end
    end
  end

  initial begin
    int n, a0, rd_cnt;
    logic [26:0] exp_held;
    rst_n = 1'b0; enable = 1'b0; pixel_ready = 1'b0; ddr3_waitrequest = 1'b0;
    tick(3);
    chk("rst_read", ddr3_read, 1'b0);
    chk("rst_addr", ddr3_read_address, 27'd0);
    chk("rst_pvalid", pixel_valid, 1'b0);
    chk("rst_pixel", pixel, 16'd0);
    chk("rst_eof", pixel_eof, 1'b0);
    chk("rst_level", fifo_level, 8'd0);
    chk("rst_burstcount", ddr3_burstcount, 8'd2);

    // First request three cycles after release
    enable = 1'b1; pixel_ready = 1'b1; rst_n = 1'b1;
    chk("first_req_c1", ddr3_read, 1'b0);
    tick(1);
    chk("first_req_c2", ddr3_read, 1'b0);
    tick(1);
    chk("first_req_c3", ddr3_read, 1'b1);
    chk("first_addr", ddr3_read_address, 27'h8);

    n = 0;
    while (!pixel_valid && n < 30) begin tick(1); n++; end
    chk("first_pixel_timeout", pixel_valid, 1'b1);
    tick(1);
    chk("return_latency", first_pv_cyc - first_beat_cyc, 2);
    bubble_win = 1'b1;
    tick(600);
    bubble_win = 1'b0;
    chk("no_bubbles", bubbles, 0);
    chk("burst_log_size", acc_log.size() >= 9, 1'b1);
    for (int i = 0; i < 9; i++)
      if (i < acc_log.size()) chk("burst_addr", acc_log[i], 27'(8 + 2 * (i % 8)));
    chk("frames_streamed", pix_total >= 512, 1'b1);
    chk("eof_count", eof_cnt, pix_total / 256);

    // Consumer stall
    pixel_ready = 1'b0;
    tick(50);
    rd_cnt = 0;
    for (int i = 0; i < 50; i++) begin tick(1); if (ddr3_read) rd_cnt++; end
    chk("stall_no_req", rd_cnt, 0);
    chk("stall_full", fifo_level >= 8'd7, 1'b1);
    pixel_ready = 1'b1;
    tick(100);
    chk("max_level", max_level <= 8, 1'b1);
    chk("max_occupancy", max_occ <= 8, 1'b1);
    chk("accept_with_beat", coincide > 0, 1'b1);

    // Waitrequest hold with enable dropped during the stall
    ddr3_waitrequest = 1'b1;
    n = 0;
    while (!ddr3_read && n < 300) begin tick(1); n++; end
    chk("held_req_timeout", ddr3_read, 1'b1);
    exp_held = nxt(acc_log[acc_log.size() - 1]);
    a0 = acc_cnt;
    chk("held_addr", ddr3_read_address, exp_held);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      if (i == 1) enable = 1'b0;
      chk("wait_read_stable", ddr3_read, 1'b1);
      chk("wait_addr_stable", ddr3_read_address, exp_held);
    end
    chk("wait_no_accept", acc_cnt, a0);
    ddr3_waitrequest = 1'b0;
    tick(1);
    chk("one_burst_counted", acc_cnt, a0 + 1);
    chk("accepted_addr", acc_log[acc_log.size() - 1], exp_held);
    rd_cnt = 0;
    for (int i = 0; i < 200; i++) begin tick(1); if (ddr3_read) rd_cnt++; end
    chk("disabled_no_req", rd_cnt, 0);
    chk("disabled_acc", acc_cnt, a0 + 1);
`ifdef DDR3_READER_UNDERRUN_CNT_EN
    chk("underrun_seen", exp_underrun > 0, 1'b1);
    chk("underrun_count", underrun_count, 16'(exp_underrun));
`endif
    enable = 1'b1;
    n = 0;
    while (acc_cnt < a0 + 2 && n < 100) begin tick(1); n++; end
    chk("reenable_timeout", acc_cnt >= a0 + 2, 1'b1);
    if (acc_log.size() > a0 + 1) chk("reenable_addr", acc_log[a0 + 1], nxt(exp_held));

    // Reset in the middle of a returning burst
    tick(30);
    n = 0;
    while (!ddr3_readdatavalid && n < 100) begin tick(1); n++; end
    chk("midburst_timeout", ddr3_readdatavalid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mrst_read", ddr3_read, 1'b0);
    chk("mrst_addr", ddr3_read_address, 27'd0);
    chk("mrst_pvalid", pixel_valid, 1'b0);
    chk("mrst_pixel", pixel, 16'd0);
    chk("mrst_eof", pixel_eof, 1'b0);
    chk("mrst_level", fifo_level, 8'd0);
`ifdef DDR3_READER_UNDERRUN_CNT_EN
    chk("mrst_underrun", underrun_count, 16'd0);
`endif
    tick(3);
    a0 = acc_log.size();
    rst_n = 1'b1;
    tick(1);
    chk("restart_c2", ddr3_read, 1'b0);
    tick(1);
    chk("restart_c3", ddr3_read, 1'b1);
    chk("restart_addr", ddr3_read_address, 27'h8);
    n = 0;
    while (!pixel_valid && n < 30) begin tick(1); n++; end
    chk("restart_pixel_timeout", pixel_valid, 1'b1);
`ifdef DDR3_READER_UNDERRUN_CNT_EN
    chk("underrun_before_first", underrun_count, 16'd0);
`endif
    tick(300);
    if (acc_log.size() > a0) chk("restart_logged_addr", acc_log[a0], 27'h8);
`ifdef DDR3_READER_UNDERRUN_CNT_EN
    chk("underrun_after_restart", underrun_count, 16'(exp_underrun));
`endif
    chk("restart_stream", pix_total > 0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
